// File: rtl/serial_word_deser_if.sv
// Bus bundle for the serial word deserializer: serial input side,
// valid/ready word output side, and the sticky status flags.
interface serial_word_deser_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     sync_in;
  logic                     bit_in;
  logic                     bit_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic                     misalign;
  logic                     clear_flags;

  // Deserializer side.
  modport slave (
    input  sync_in, bit_in, bit_valid, out_ready, clear_flags,
    output out_data, out_valid, fifo_count, overflow, misalign
  );

  // Producer/consumer side.
  modport master (
    output sync_in, bit_in, bit_valid, out_ready, clear_flags,
    input  out_data, out_valid, fifo_count, overflow, misalign
  );
endinterface

// File: rtl/serial_word_deser.sv
// Serial word deserializer: samples an MSB-first bit stream framed by a
// sync strobe, reassembles WIDTH-bit words and queues them in a small
// FIFO with a valid/ready output. Overflow and misalign are sticky.
module serial_word_deser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_word_deser_if.slave  s_bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_push, w_misalign_evt;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             r_overflow, r_misalign;
  logic             w_pop, w_push_ok, w_drop;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  // Receiver next-state: sync always restarts a word; a sync in RECV means
  // the partial word is abandoned and flagged.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shreg_nxt    = r_shreg;
    w_push         = 1'b0;
    w_misalign_evt = 1'b0;
    w_word         = {r_shreg[WIDTH-2:0], s_bus.bit_in};
    if (s_bus.bit_valid) begin
      if (s_bus.sync_in) begin
        w_misalign_evt = (r_state == RECV);
        w_shreg_nxt    = {{(WIDTH-1){1'b0}}, s_bus.bit_in};
        w_cnt_nxt      = CW'(1);
        w_state_nxt    = RECV;
      end else if (r_state == RECV) begin
        w_shreg_nxt = w_word;
        if (r_cnt == CW'(WIDTH-1)) begin
          w_push      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    end
  end

  // A pop at the same edge frees a slot, so a full FIFO can still accept.
  assign w_pop     = (r_count != '0) && s_bus.out_ready;
  assign w_push_ok = w_push && ((r_count < (AW+1)'(DEPTH)) || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flags; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_drop)                 r_overflow <= 1'b1;
      else if (s_bus.clear_flags) r_overflow <= 1'b0;
      if (w_misalign_evt)         r_misalign <= 1'b1;
      else if (s_bus.clear_flags) r_misalign <= 1'b0;
    end
  end

  assign s_bus.out_valid  = (r_count != '0);
  assign s_bus.out_data   = (r_count != '0) ? r_mem[r_rptr] : '0;
  assign s_bus.fifo_count = r_count;
  assign s_bus.overflow   = r_overflow;
  assign s_bus.misalign   = r_misalign;
endmodule

// File: tb/tb_serial_word_deser.sv
// Directed bench: stimulus pushes expected words into a queue, a monitor
// pops and compares on every accepted output handshake.
module tb_serial_word_deser;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_word_deser_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  serial_word_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h expected=none", bus.out_data);
      end else begin
        check("word", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic b);
    bus.bit_valid = 1'b1;
    bus.sync_in   = s;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
    bus.sync_in   = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH-1; i >= 0; i--) send_bit(i == WIDTH-1, w[i]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.fifo_count != 0 && n < 20) begin
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    check("drain_empty", {29'd0, bus.fifo_count}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_data"},  {24'd0, bus.out_data},  32'd0);
    check({tag, "_count"}, {29'd0, bus.fifo_count}, 32'd0);
    check({tag, "_ovf"},   {31'd0, bus.overflow},  32'd0);
    check({tag, "_mis"},   {31'd0, bus.misalign},  32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    bus.sync_in = 0; bus.bit_in = 0; bus.bit_valid = 0;
    bus.out_ready = 0; bus.clear_flags = 0;

    // Reset state
    rst = 1; tick(); tick(); rst = 0;
    check_idle_outputs("reset");

    // 0xA5 back-to-back, latency and single pop
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(i == 7, w[i]);
    check("a5_not_yet_valid", {31'd0, bus.out_valid}, 32'd0);
    send_bit(1'b0, w[0]);
    check("a5_valid", {31'd0, bus.out_valid}, 32'd1);
    check("a5_data", {24'd0, bus.out_data}, 32'hA5);
    check("a5_count", {29'd0, bus.fifo_count}, 32'd1);
    exp_q.push_back(8'hA5);
    bus.out_ready = 1; tick(); bus.out_ready = 0;
    check("a5_count_after_pop", {29'd0, bus.fifo_count}, 32'd0);
    check("a5_valid_after_pop", {31'd0, bus.out_valid}, 32'd0);

    // 0x3C with a 3-cycle gap after the third bit
    w = 8'h3C;
    for (int i = 7; i >= 5; i--) send_bit(i == 7, w[i]);
    repeat (3) tick();
    for (int i = 4; i >= 0; i--) send_bit(1'b0, w[i]);
    check("3c_data", {24'd0, bus.out_data}, 32'h3C);
    exp_q.push_back(8'h3C);
    drain();
    check("3c_ovf", {31'd0, bus.overflow}, 32'd0);
    check("3c_mis", {31'd0, bus.misalign}, 32'd0);

    // Overflow: five words into a 4-deep FIFO
    for (int k = 1; k <= 5; k++) begin
      send_word(WIDTH'(k));
      if (k <= 4) exp_q.push_back(WIDTH'(k));
    end
    check("ovf_count", {29'd0, bus.fifo_count}, 32'd4);
    check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    drain();
    check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.clear_flags = 1; tick(); bus.clear_flags = 0;
    check("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

    // Full FIFO, simultaneous pop and push
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44); exp_q.push_back(8'h77);
    w = 8'h77;
    for (int i = 7; i >= 1; i--) send_bit(i == 7, w[i]);
    check("full_count_pre", {29'd0, bus.fifo_count}, 32'd4);
    bus.out_ready = 1;
    send_bit(1'b0, w[0]);
    bus.out_ready = 0;
    check("full_count_post", {29'd0, bus.fifo_count}, 32'd4);
    check("full_no_ovf", {31'd0, bus.overflow}, 32'd0);
    check("full_new_head", {24'd0, bus.out_data}, 32'h22);
    drain();

    // Misalign: 4 bits of 0xF0 then a fresh 0x81
    w = 8'hF0;
    for (int i = 7; i >= 4; i--) send_bit(i == 7, w[i]);
    send_word(8'h81);
    exp_q.push_back(8'h81);
    check("mis_flag", {31'd0, bus.misalign}, 32'd1);
    check("mis_count", {29'd0, bus.fifo_count}, 32'd1);
    check("mis_data", {24'd0, bus.out_data}, 32'h81);
    drain();
    // Clear while a new misalign event arrives: set wins
    w = 8'hFF;
    for (int i = 7; i >= 5; i--) send_bit(i == 7, w[i]);
    bus.clear_flags = 1;
    send_bit(1'b1, 1'b0);
    bus.clear_flags = 0;
    check("mis_set_wins", {31'd0, bus.misalign}, 32'd1);
    bus.clear_flags = 1; tick(); bus.clear_flags = 0;
    check("mis_cleared", {31'd0, bus.misalign}, 32'd0);

    // Reset mid-word discards the partial word
    w = 8'hFF;
    for (int i = 7; i >= 3; i--) send_bit(i == 7, w[i]);
    rst = 1; tick(); rst = 0;
    check_idle_outputs("midrst");
    send_word(8'hC3);
    exp_q.push_back(8'hC3);
    check("c3_count", {29'd0, bus.fifo_count}, 32'd1);
    check("c3_data", {24'd0, bus.out_data}, 32'hC3);
    drain();
    check("c3_mis", {31'd0, bus.misalign}, 32'd0);

    // Empty FIFO ignores out_ready
    bus.out_ready = 1; tick(); tick(); bus.out_ready = 0;
    check("empty_ready_count", {29'd0, bus.fifo_count}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
